// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides; single-cycle ops return in 1 cycle, MUL in W+1.
// Throughput is one op per two cycles: a result must be handed off before the next accept.
module alu_seq #(
  parameter int W  = 16,
  parameter int CW = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] z,
  output logic         zflag,
  output logic         cflag,
  output logic         nflag
);

  localparam int SW = $clog2(W);

  localparam logic [3:0] OP_SUB = 4'd0;
  localparam logic [3:0] OP_INC = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;

  logic [SW-1:0]  shamt;
  logic [W:0]     wide_arith;
  logic [W:0]     wide_shl;
  logic [W:0]     wide_shr;
  logic [W-1:0]   res;
  logic           res_c;
  logic [2*W-1:0] acc_nxt;

  // Shifts run one bit wider so the last bit shifted out lands in the extra bit.
  always_comb begin
    shamt      = y[SW-1:0];
    wide_arith = '0;
    wide_shl   = {1'b0, x} << shamt;
    wide_shr   = {x, 1'b0} >> shamt;
    res        = '0;
    res_c      = 1'b0;
    case (op)
      OP_SUB: begin
        wide_arith = {1'b0, x} - {1'b0, y};
        res        = wide_arith[W-1:0];
        res_c      = wide_arith[W];
      end
      OP_INC: begin
        wide_arith = {1'b0, x} + (W+1)'(1);
        res        = wide_arith[W-1:0];
        res_c      = wide_arith[W];
      end
      OP_ADD: begin
        wide_arith = {1'b0, x} + {1'b0, y};
        res        = wide_arith[W-1:0];
        res_c      = wide_arith[W];
      end
      OP_OR:  res = x | y;
      OP_AND: res = x & y;
      OP_XOR: res = x ^ y;
      OP_SHL: begin
        res   = wide_shl[W-1:0];
        res_c = wide_shl[W];
      end
      OP_SHR: begin
        res   = wide_shr[W:1];
        res_c = wide_shr[0];
      end
      default: begin
        res   = '0;
        res_c = 1'b0;
      end
    endcase
  end

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      z         <= '0;
      zflag     <= 1'b0;
      cflag     <= 1'b0;
      nflag     <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (op == OP_MUL) begin
              mcand  <= {{W{1'b0}}, x};
              mplier <= y;
              acc    <= '0;
              cnt    <= CW'(W);
              state  <= BUSY;
            end else begin
              z         <= res;
              zflag     <= (res == '0);
              cflag     <= res_c;
              nflag     <= res[W-1];
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          // Last partial product: publish straight from the adder output.
          if (cnt == CW'(1)) begin
            z         <= acc_nxt[W-1:0];
            zflag     <= (acc_nxt[W-1:0] == '0);
            cflag     <= |acc_nxt[2*W-1:W];
            nflag     <= acc_nxt[W-1];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at W=16.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [15:0] x = 16'h0;
  logic [15:0] y = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] z;
  logic        zflag, cflag, nflag;
  logic [19:0] obs;

  int checks = 0;
  int failures = 0;

  alu_seq #(.W(16), .CW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .zflag(zflag), .cflag(cflag), .nflag(nflag)
  );

  always #5 clk = ~clk;

  // {out_valid, z, zflag, cflag, nflag}
  assign obs = {out_valid, z, zflag, cflag, nflag};

  // Present a request for one edge (caller ensures IDLE), then scramble operands.
  task automatic send(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    op = o; x = a; y = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; x = ~a; y = ~b; op = 4'd3;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, obs} !== {1'b1, 1'b0, 16'h0000, 3'b000}) begin
      failures++;
      $display("FAIL reset got rdy=%b obs=%h want rdy=1 obs=00000", in_ready, obs);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sub();
    send(4'd0, 16'd5, 16'd5);
    checks++;
    if ({in_ready, obs} !== {1'b0, 1'b1, 16'h0000, 3'b100}) begin
      failures++;
      $display("FAIL sub_eq got rdy=%b obs=%h want rdy=0 obs=%h", in_ready, obs, {1'b1, 16'h0000, 3'b100});
    end
    handoff();
    send(4'd0, 16'd3, 16'd5);
    checks++;
    if (obs !== {1'b1, 16'hFFFE, 3'b011}) begin
      failures++;
      $display("FAIL sub_borrow got %h want %h", obs, {1'b1, 16'hFFFE, 3'b011});
    end
    handoff();
  endtask

  task automatic test_inc_add();
    send(4'd1, 16'hFFFF, 16'h1234);
    checks++;
    if (obs !== {1'b1, 16'h0000, 3'b110}) begin
      failures++;
      $display("FAIL inc_wrap got %h want %h", obs, {1'b1, 16'h0000, 3'b110});
    end
    handoff();
    send(4'd3, 16'h8000, 16'h8000);
    checks++;
    if (obs !== {1'b1, 16'h0000, 3'b110}) begin
      failures++;
      $display("FAIL add_carry got %h want %h", obs, {1'b1, 16'h0000, 3'b110});
    end
    handoff();
  endtask

  task automatic test_logic();
    send(4'd4, 16'hF0F0, 16'h0FF0);
    checks++;
    if (obs !== {1'b1, 16'h00F0, 3'b000}) begin
      failures++;
      $display("FAIL and got %h want %h", obs, {1'b1, 16'h00F0, 3'b000});
    end
    handoff();
    send(4'd5, 16'hFFFF, 16'h0001);
    checks++;
    if (obs !== {1'b1, 16'hFFFE, 3'b001}) begin
      failures++;
      $display("FAIL xor got %h want %h", obs, {1'b1, 16'hFFFE, 3'b001});
    end
    handoff();
  endtask

  task automatic test_mul_case(input logic [15:0] a, input logic [15:0] b,
                               input logic [18:0] want, input string name);
    int n;
    logic rdy_seen;
    send(4'd8, a, b);
    // A request presented during BUSY/DONE must be ignored.
    op = 4'd3; x = 16'h0001; y = 16'h0001; in_valid = 1'b1;
    n = 1;
    rdy_seen = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 17) begin
      failures++;
      $display("FAIL %s_latency got %0d cycles want 17", name, n);
    end
    checks++;
    if (rdy_seen !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_rdy got in_ready=1 during BUSY want 0", name);
    end
    checks++;
    if (obs !== {1'b1, want}) begin
      failures++;
      $display("FAIL %s_result got %h want %h", name, obs, {1'b1, want});
    end
    in_valid = 1'b0;
    handoff();
  endtask

  task automatic test_mul();
    test_mul_case(16'd300, 16'd300, {16'h5F90, 3'b010}, "mul300");
    test_mul_case(16'd255, 16'd255, {16'hFE01, 3'b001}, "mul255");
  endtask

  task automatic test_backpressure();
    logic bad;
    send(4'd2, 16'h0F0F, 16'h00F0);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if ({in_ready, obs} !== {1'b0, 1'b1, 16'h0FFF, 3'b000}) bad = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad !== 1'b0 || {in_ready, obs} !== {1'b0, 1'b1, 16'h0FFF, 3'b000}) begin
      failures++;
      $display("FAIL bp_hold got rdy=%b obs=%h want rdy=0 obs=%h", in_ready, obs, {1'b1, 16'h0FFF, 3'b000});
    end
    handoff();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_shift();
    send(4'd6, 16'h8001, 16'h0001);
    checks++;
    if (obs !== {1'b1, 16'h0002, 3'b010}) begin
      failures++;
      $display("FAIL shl1 got %h want %h", obs, {1'b1, 16'h0002, 3'b010});
    end
    handoff();
    send(4'd6, 16'h8001, 16'h0010);
    checks++;
    if (obs !== {1'b1, 16'h8001, 3'b001}) begin
      failures++;
      $display("FAIL shl0 got %h want %h", obs, {1'b1, 16'h8001, 3'b001});
    end
    handoff();
    send(4'd7, 16'h0003, 16'h0001);
    checks++;
    if (obs !== {1'b1, 16'h0001, 3'b010}) begin
      failures++;
      $display("FAIL shr1 got %h want %h", obs, {1'b1, 16'h0001, 3'b010});
    end
    handoff();
  endtask

  task automatic test_reserved();
    send(4'd12, 16'hABCD, 16'h1234);
    checks++;
    if (obs !== {1'b1, 16'h0000, 3'b100}) begin
      failures++;
      $display("FAIL reserved got %h want %h", obs, {1'b1, 16'h0000, 3'b100});
    end
    handoff();
  endtask

  task automatic test_back_to_back();
    send(4'd3, 16'd1, 16'd2);
    handoff();
    send(4'd3, 16'd40, 16'd2);
    checks++;
    if (obs !== {1'b1, 16'd42, 3'b000}) begin
      failures++;
      $display("FAIL b2b got %h want %h", obs, {1'b1, 16'd42, 3'b000});
    end
    handoff();
  endtask

  task automatic test_mul_reset();
    logic seen;
    send(4'd8, 16'd300, 16'd300);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, z} !== {1'b1, 1'b0, 16'h0000}) begin
      failures++;
      $display("FAIL mul_rst got rdy=%b vld=%b z=%h want rdy=1 vld=0 z=0000", in_ready, out_valid, z);
    end
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL mul_rst_ghost got out_valid=1 after reset want 0");
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_inc_add();
    test_logic();
    test_mul();
    test_backpressure();
    test_shift();
    test_reserved();
    test_back_to_back();
    test_mul_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor of the microcode combinational ALU. It accepts operations through a valid/ready handshake and returns the result plus Z/C/N flags through a valid/ready output. Most ops complete in one cycle; MUL runs as a W-cycle iterative shift-add. It sits between the microcode sequencer and the register file, and the sequencer stalls on in_ready.

Parameters:
W, 16, operand/result width in bits (legal range 4..32)
CW, 5, width of the internal multiply cycle counter; must be at least clog2(W)+1

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operation request valid
in_ready  out  1  block can accept a request this cycle
op  in  4  opcode: 0 SUB, 1 INC, 2 OR, 3 ADD, 4 AND, 5 XOR, 6 SHL, 7 SHR, 8 MUL; 9..15 reserved
x  in  W  operand A
y  in  W  operand B (shift amount for SHL/SHR: low clog2(W) bits)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
z  out  W  result
zflag  out  1  z == 0
cflag  out  1  carry/borrow/overflow, per op
nflag  out  1  z[W-1]

Behaviour:
- One clock. Reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, z=0, zflag=0, cflag=0, nflag=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. Request is accepted on in_valid&in_ready.
  - Single-cycle op: next cycle state=DONE with z and flags registered (1-cycle latency).
  - MUL: latch x, y, clear the accumulator, load counter=W, go to BUSY.
- BUSY: in_ready=0. Each cycle:
  - add the shifted multiplicand to the 2W-bit accumulator if the current multiplier LSB=1;
  - shift the multiplicand left and the multiplier right;
  - decrement the counter.
  - When the counter reaches 0, go to DONE. MUL latency from accept to out_valid is W+1 cycles.
- DONE: out_valid=1, in_ready=0. z and flags are held stable until out_valid&out_ready, then go to IDLE. There is no accept in the same cycle as the handoff, so back-to-back throughput is 1 op per 2 cycles.
- Arithmetic, all modulo 2^W:
  - SUB: z=x-y, cflag=borrow (x<y unsigned).
  - INC: z=x+1, cflag=(x==all ones).
  - ADD: z=x+y, cflag=carry out of bit W-1.
  - OR, AND, XOR: cflag=0.
  - SHL: z=x<<s, cflag=last bit shifted out (0 if s=0).
  - SHR: logical shift, z=x>>s, cflag=last bit shifted out (0 if s=0).
  - MUL: z=low W bits of the product, cflag=(high W bits != 0).
- zflag=(z==0) and nflag=z[W-1] for every op, registered with z.
- Reserved opcode: accepted, z=0, zflag=1, cflag=0, nflag=0, 1-cycle latency.
- Input operands are captured at accept; x/y/op changes after accept have no effect.
- rst asserted in any state, including mid-MUL or DONE with out_ready low, returns to the reset values next cycle. The in-flight op is discarded with no out_valid pulse.
- in_valid while in_ready=0 is ignored; the requester must hold the request until accepted.

Test Plan:
- W=16, SUB x=5 y=5 -> 1 cycle later out_valid=1, z=0, zflag=1, cflag=0, nflag=0. SUB x=3 y=5 -> z=0xFFFE, cflag=1, nflag=1.
- INC x=0xFFFF -> z=0, zflag=1, cflag=1. ADD x=0x8000 y=0x8000 -> z=0, cflag=1.
- MUL x=300 y=300 (W=16) -> out_valid exactly 17 cycles after accept, z=0x5F90, cflag=1. MUL x=255 y=255 -> z=0xFE01, cflag=0. in_ready=0 throughout BUSY.
- Backpressure: out_ready held 0 for 5 cycles after OR x=0x0F0F y=0x00F0 -> z=0x0FFF and flags held stable, in_ready=0. Raise out_ready -> handoff, then IDLE with in_ready=1.
- SHL x=0x8001 y=1 -> z=0x0002, cflag=1. SHR x=0x0003 y=1 -> z=0x0001, cflag=1. Reserved op=12 -> z=0, zflag=1.
- rst asserted 4 cycles into a MUL -> next cycle in_ready=1, out_valid=0, z=0, and no result appears afterward.
